// File: rtl/uart_cmd_pkg.sv
// Shared types for the UART command decoder: FSM states, command codes, ASCII map and byte decoder.
package uart_cmd_pkg;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned BTN_N     = 3;
    localparam int unsigned BTN_RUN   = 0;
    localparam int unsigned BTN_CLEAR = 1;
    localparam int unsigned BTN_MODE  = 2;

    localparam logic [BYTE_W-1:0] ASCII_R_UC = 8'h52;
    localparam logic [BYTE_W-1:0] ASCII_R_LC = 8'h72;
    localparam logic [BYTE_W-1:0] ASCII_C_UC = 8'h43;
    localparam logic [BYTE_W-1:0] ASCII_C_LC = 8'h63;
    localparam logic [BYTE_W-1:0] ASCII_M_UC = 8'h4D;
    localparam logic [BYTE_W-1:0] ASCII_M_LC = 8'h6D;

    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EMIT, ECHO, HOLD} state_e;
    typedef enum logic [1:0] {CMD_NONE, CMD_RUN, CMD_CLEAR, CMD_MODE} cmd_e;

    typedef struct packed {
        logic mode;
        logic clear;
        logic enable;
    } cmd_pulse_t;

    function automatic cmd_e decode_byte(input logic [BYTE_W-1:0] b);
        case (b)
            ASCII_R_UC, ASCII_R_LC: decode_byte = CMD_RUN;
            ASCII_C_UC, ASCII_C_LC: decode_byte = CMD_CLEAR;
            ASCII_M_UC, ASCII_M_LC: decode_byte = CMD_MODE;
            default:                decode_byte = CMD_NONE;
        endcase
    endfunction

    function automatic cmd_pulse_t cmd_to_pulse(input cmd_e c);
        cmd_to_pulse        = '0;
        cmd_to_pulse.enable = (c == CMD_RUN);
        cmd_to_pulse.clear  = (c == CMD_CLEAR);
        cmd_to_pulse.mode   = (c == CMD_MODE);
    endfunction

endpackage

// File: rtl/uart_cmd_decoder_if.sv
// Bus bundle between the UART FIFOs / buttons and the command decoder.
interface uart_cmd_decoder_if #(
    parameter int unsigned ERR_W = 8
);
    logic             i_rx_empty;
    logic [7:0]       i_rx_data;
    logic             o_rx_pop;
    logic             i_btn_run;
    logic             i_btn_clear;
    logic             i_btn_mode;
    logic             o_enable;
    logic             o_clear;
    logic             o_mode;
    logic             o_err;
    logic [ERR_W-1:0] o_err_cnt;
    logic             i_tx_full;
    logic             o_tx_push;
    logic [7:0]       o_tx_data;

    modport slave (
        input  i_rx_empty, i_rx_data, i_btn_run, i_btn_clear, i_btn_mode, i_tx_full,
        output o_rx_pop, o_enable, o_clear, o_mode, o_err, o_err_cnt, o_tx_push, o_tx_data
    );

    modport master (
        output i_rx_empty, i_rx_data, i_btn_run, i_btn_clear, i_btn_mode, i_tx_full,
        input  o_rx_pop, o_enable, o_clear, o_mode, o_err, o_err_cnt, o_tx_push, o_tx_data
    );
endinterface

// File: rtl/btn_pending_latch.sv
// Per-button pending flags; a pulse on an already-pending button is absorbed.
// Fixed priority select run > clear > mode; take_i clears only the selected flag.
module btn_pending_latch
    import uart_cmd_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [BTN_N-1:0] pulse_i,
    input  logic             take_i,
    output logic             pend_o,
    output cmd_e             sel_o
);

    logic [BTN_N-1:0] flags_q;
    logic [BTN_N-1:0] flags_d;
    logic [BTN_N-1:0] chosen_c;

    always_comb begin
        chosen_c = '0;
        sel_o    = CMD_NONE;
        if (flags_q[BTN_RUN]) begin
            chosen_c[BTN_RUN] = 1'b1;
            sel_o             = CMD_RUN;
        end else if (flags_q[BTN_CLEAR]) begin
            chosen_c[BTN_CLEAR] = 1'b1;
            sel_o               = CMD_CLEAR;
        end else if (flags_q[BTN_MODE]) begin
            chosen_c[BTN_MODE] = 1'b1;
            sel_o              = CMD_MODE;
        end
    end

    always_comb begin
        flags_d = flags_q;
        for (int i = 0; i < int'(BTN_N); i++) begin
            flags_d[i] = flags_q[i] ? !(take_i && chosen_c[i]) : pulse_i[i];
        end
    end

    assign pend_o = |flags_q;

    always_ff @(posedge clk) begin
        if (rst) flags_q <= '0;
        else     flags_q <= flags_d;
    end

endmodule

// File: rtl/uart_cmd_decoder.sv
// Turns UART command bytes and button pulses into paced single-cycle control pulses.
// Optional CMD_ECHO_EN: echo each accepted UART command byte to the TX FIFO.
module uart_cmd_decoder
    import uart_cmd_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 2,
    parameter int unsigned ERR_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    uart_cmd_decoder_if.slave bus
);

    localparam int unsigned GAP_EFF = (GAP_CYCLES < 2) ? 2 : GAP_CYCLES;
    localparam int unsigned GAP_W   = $clog2(GAP_EFF);

    state_e            state_q, state_d;
    logic [BYTE_W-1:0] cmd_q, cmd_d;
    logic              src_uart_q, src_uart_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
    cmd_pulse_t        pulse_q, pulse_d;
    logic              pop_q, pop_d;
    logic              err_q, err_d;

    logic              btn_take;
    logic              btn_pend;
    cmd_e              btn_sel;

    btn_pending_latch u_btn (
        .clk     (clk),
        .rst     (rst),
        .pulse_i ({bus.i_btn_mode, bus.i_btn_clear, bus.i_btn_run}),
        .take_i  (btn_take),
        .pend_o  (btn_pend),
        .sel_o   (btn_sel)
    );

    // Outputs are computed one state early so they register into the cycle of their state.
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        src_uart_d = src_uart_q;
        gap_d      = gap_q;
        err_cnt_d  = err_cnt_q;
        pulse_d    = '0;
        pop_d      = 1'b0;
        err_d      = 1'b0;
        btn_take   = 1'b0;
        case (state_q)
            IDLE: begin
                if (btn_pend) begin
                    btn_take   = 1'b1;
                    pulse_d    = cmd_to_pulse(btn_sel);
                    src_uart_d = 1'b0;
                    state_d    = EMIT;
                end else if (!bus.i_rx_empty) begin
                    pop_d   = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                cmd_d   = bus.i_rx_data;
                state_d = DECODE;
                if (decode_byte(bus.i_rx_data) == CMD_NONE) begin
                    err_d = 1'b1;
                    if (err_cnt_q != {ERR_W{1'b1}}) err_cnt_d = err_cnt_q + ERR_W'(1);
                end
            end
            DECODE: begin
                if (decode_byte(cmd_q) != CMD_NONE) begin
                    pulse_d    = cmd_to_pulse(decode_byte(cmd_q));
                    src_uart_d = 1'b1;
                    state_d    = EMIT;
                end else begin
                    state_d = IDLE;
                end
            end
            EMIT: begin
                gap_d = GAP_W'(GAP_EFF - 1);
`ifdef CMD_ECHO_EN
                state_d = src_uart_q ? ECHO : HOLD;
`else
                state_d = HOLD;
`endif
            end
`ifdef CMD_ECHO_EN
            ECHO: begin
                if (gap_q != '0) gap_d = gap_q - GAP_W'(1);
                if (!bus.i_tx_full) state_d = HOLD;
            end
`endif
            HOLD: begin
                if (gap_q <= GAP_W'(1)) begin
                    gap_d   = '0;
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cmd_q      <= '0;
            src_uart_q <= 1'b0;
            gap_q      <= '0;
            err_cnt_q  <= '0;
            pulse_q    <= '0;
            pop_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            src_uart_q <= src_uart_d;
            gap_q      <= gap_d;
            err_cnt_q  <= err_cnt_d;
            pulse_q    <= pulse_d;
            pop_q      <= pop_d;
            err_q      <= err_d;
        end
    end

    assign bus.o_rx_pop  = pop_q;
    assign bus.o_enable  = pulse_q.enable;
    assign bus.o_clear   = pulse_q.clear;
    assign bus.o_mode    = pulse_q.mode;
    assign bus.o_err     = err_q;
    assign bus.o_err_cnt = err_cnt_q;

`ifdef CMD_ECHO_EN
    // Push must see the live full flag, so it is decoded from state rather than registered.
    logic push_c;
    assign push_c        = (state_q == ECHO) && !bus.i_tx_full && !rst;
    assign bus.o_tx_push = push_c;
    assign bus.o_tx_data = push_c ? cmd_q : '0;
`else
    logic unused_tx_full;
    assign unused_tx_full = bus.i_tx_full;
    assign bus.o_tx_push  = 1'b0;
    assign bus.o_tx_data  = '0;
`endif

endmodule
